// File: rtl/uart8_rx_fifo.sv
// uart8_rx_fifo: buffer stage behind the 8-bit UART receiver.
// Captures each completed byte on the rising edge of rx_done into a
// first-word-fall-through FIFO and presents it on a valid/ready stream.
// Framing errors and overruns are tracked in sticky bits and saturating
// counters.
// Optional feature macro: UART_RX_FIFO_IDLE_TIMEOUT_EN. It enables a
// one-shot idle-line pulse on rx_idle.
// Ports:
//   clk, rst_n             oversample clock, synchronous active-low reset
//   rx_data/rx_done/rx_err receiver byte, done level and error level
//   m_data/m_valid/m_ready FIFO head stream to the host
//   level/full             occupancy and full flag
//   flush/clr_status       FIFO clear and status clear
//   frame_err/overrun      sticky status bits
//   err_cnt/drop_cnt       saturating event counters
//   rx_idle                end-of-burst pulse (0 without the macro)
module uart8_rx_fifo #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned IDLE_CLKS = 160
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               rx_data,
   input  logic                     rx_done,
   input  logic                     rx_err,
   output logic [7:0]               m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   input  logic                     flush,
   input  logic                     clr_status,
   output logic                     frame_err,
   output logic                     overrun,
   output logic [CNT_W-1:0]         err_cnt,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic                     rx_idle
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   // Elaboration-time parameter sanity checks
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of two >= 2");
   end
   if (IDLE_CLKS < 1) begin : g_bad_idle
      $error("IDLE_CLKS must be >= 1");
   end

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             full_q, full_d, m_valid_q, m_valid_d;
   logic [7:0]       m_data_q, m_data_d;
   logic             rx_done_q, rx_err_q;
   logic             frame_err_q, frame_err_d, overrun_q, overrun_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;
   logic             push_evt, err_evt, pop, do_push, drop;

   // Event detection, FIFO bookkeeping and status next-state
   always_comb begin
      push_evt    = rx_done & ~rx_done_q;
      err_evt     = rx_err & ~rx_err_q;
      pop         = m_valid_q & m_ready & ~flush;
      // When full, a same-cycle pop frees the slot the push lands in
      do_push     = push_evt & ~flush & (~full_q | pop);
      drop        = push_evt & ~flush & full_q & ~pop;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      m_data_d    = m_data_q;
      frame_err_d = clr_status ? 1'b0 : frame_err_q;
      overrun_d   = clr_status ? 1'b0 : overrun_q;
      err_cnt_d   = clr_status ? '0 : err_cnt_q;
      drop_cnt_d  = clr_status ? '0 : drop_cnt_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
         level_d = level_q + LVL_W'(do_push) - LVL_W'(pop);
      end

      // Next head: bypass the incoming byte when it lands in the head slot
      if (level_d != '0) begin
         if (do_push && (wr_ptr_q == rd_ptr_d)) m_data_d = rx_data;
         else                                   m_data_d = mem_q[rd_ptr_d];
      end
      m_valid_d = (level_d != '0);
      full_d    = (level_d == LVL_W'(DEPTH));

      // Events override a coincident clear
      if (err_evt) begin
         frame_err_d = 1'b1;
         if (err_cnt_d != '1) err_cnt_d = err_cnt_d + CNT_W'(1);
      end
      if (drop) begin
         overrun_d = 1'b1;
         if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + CNT_W'(1);
      end
   end

   // Storage array, no reset needed: reads are qualified by level
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= rx_data;
   end

   // Control and status registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         full_q      <= 1'b0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         rx_done_q   <= 1'b0;
         rx_err_q    <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         err_cnt_q   <= '0;
         drop_cnt_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         full_q      <= full_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         rx_done_q   <= rx_done;
         rx_err_q    <= rx_err;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         err_cnt_q   <= err_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign m_data    = m_data_q;
   assign m_valid   = m_valid_q;
   assign level     = level_q;
   assign full      = full_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign err_cnt   = err_cnt_q;
   assign drop_cnt  = drop_cnt_q;

`ifdef UART_RX_FIFO_IDLE_TIMEOUT_EN
   localparam int unsigned IDLE_W = $clog2(IDLE_CLKS + 1);

   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic              rx_idle_q, rx_idle_d;

   // Idle counter: saturates at IDLE_CLKS so each burst yields one pulse
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      rx_idle_d  = 1'b0;
      if (push_evt || flush) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q != IDLE_W'(IDLE_CLKS)) begin
         idle_cnt_d = idle_cnt_q + IDLE_W'(1);
         rx_idle_d  = (idle_cnt_d == IDLE_W'(IDLE_CLKS)) && (level_d != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idle_cnt_q <= '0;
         rx_idle_q  <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         rx_idle_q  <= rx_idle_d;
      end
   end

   assign rx_idle = rx_idle_q;
`else
   assign rx_idle = 1'b0;
`endif

endmodule

// File: tb/tb_uart8_rx_fifo.sv
// Testbench for uart8_rx_fifo: directed scenarios followed by randomized
// traffic, checked every cycle against a queue-based reference model.
module tb_uart8_rx_fifo;
   localparam int DEPTH     = 16;
   localparam int CNT_W     = 8;
   localparam int IDLE_CLKS = 160;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [7:0]       rx_data;
   logic             rx_done, rx_err, m_ready, flush, clr_status;
   logic [7:0]       m_data;
   logic             m_valid, full, frame_err, overrun, rx_idle;
   logic [4:0]       level;
   logic [CNT_W-1:0] err_cnt, drop_cnt;

   uart8_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .IDLE_CLKS(IDLE_CLKS)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
      .rx_err(rx_err), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .level(level), .full(full), .flush(flush), .clr_status(clr_status),
      .frame_err(frame_err), .overrun(overrun), .err_cnt(err_cnt),
      .drop_cnt(drop_cnt), .rx_idle(rx_idle));

   always #5 clk = ~clk;

   // Reference model state
   byte unsigned q[$];
   bit  prev_done, prev_err, e_fe, e_ov, e_idle;
   int  e_err, e_drop, since, idle_pulses;
   int  n_assert = 0;
   int  n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one clock edge of the specified behaviour to the model
   task automatic model_edge();
      bit push, errv, pop, drop;
      if (!rst_n) begin
         q.delete();
         prev_done = 0; prev_err = 0;
         e_fe = 0; e_ov = 0; e_err = 0; e_drop = 0;
         since = 0; e_idle = 0;
         return;
      end
      push = rx_done && !prev_done;
      errv = rx_err && !prev_err;
      prev_done = rx_done;
      prev_err  = rx_err;
      pop  = (q.size() != 0) && m_ready;
      drop = 0;
      if (flush) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            if (q.size() < DEPTH) q.push_back(rx_data);
            else drop = 1;
         end
      end
      if (clr_status) begin e_fe = 0; e_ov = 0; e_err = 0; e_drop = 0; end
      if (errv) begin e_fe = 1; if (e_err < CNT_MAX) e_err++; end
      if (drop) begin e_ov = 1; if (e_drop < CNT_MAX) e_drop++; end
      if (push || flush) since = 0; else since++;
`ifdef UART_RX_FIFO_IDLE_TIMEOUT_EN
      e_idle = (since == IDLE_CLKS) && (q.size() != 0);
`else
      e_idle = 0;
`endif
   endtask

   task automatic check_all();
      chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
      chk("level", 32'(level), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      if (q.size() != 0) chk("m_data", 32'(m_data), 32'(q[0]));
      chk("frame_err", 32'(frame_err), 32'(e_fe));
      chk("overrun", 32'(overrun), 32'(e_ov));
      chk("err_cnt", 32'(err_cnt), 32'(e_err));
      chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
      chk("rx_idle", 32'(rx_idle), 32'(e_idle));
      if (rx_idle === 1'b1) idle_pulses++;
   endtask

   // One clock: model and DUT see the same inputs; outputs checked just after
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic push_byte(input byte unsigned b);
      rx_data = b; rx_done = 1'b1;
      cycle();
      rx_done = 1'b0;
      cycle();
   endtask

   initial begin
      byte unsigned exp_tail [16];
      rst_n = 1'b0; rx_data = '0; rx_done = 0; rx_err = 0;
      m_ready = 0; flush = 0; clr_status = 0; idle_pulses = 0;
      @(negedge clk);
      cycle(); cycle();
      chk("rst_m_data", 32'(m_data), 32'h0);
      chk("rst_m_valid", 32'(m_valid), 32'h0);
      rst_n = 1'b1;
      cycle();

      // Basic FWFT pass-through with a ready consumer
      m_ready = 1'b1;
      rx_data = 8'h55; rx_done = 1'b1; cycle();
      chk("t1_first", 32'(m_data), 32'h55);
      rx_done = 1'b0; cycle();
      push_byte(8'hA3);
      push_byte(8'h0F);
      chk("t1_level", 32'(level), 32'h0);

      // Overflow: two drops, then ordered drain
      m_ready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) push_byte(8'(i));
      chk("t2_full", 32'(full), 32'h1);
      chk("t2_level", 32'(level), 32'd16);
      chk("t2_overrun", 32'(overrun), 32'h1);
      chk("t2_drop", 32'(drop_cnt), 32'd2);
      m_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("t2_drain%0d", i), 32'(m_data), 32'(i));
         cycle();
      end
      m_ready = 1'b0;

      // Full FIFO with simultaneous pop and push
      clr_status = 1'b1; cycle(); clr_status = 1'b0;
      for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h20 + i));
      rx_data = 8'hEE; rx_done = 1'b1; m_ready = 1'b1; cycle();
      rx_done = 1'b0; m_ready = 1'b0;
      chk("t3_level", 32'(level), 32'd16);
      chk("t3_overrun", 32'(overrun), 32'h0);
      for (int i = 0; i < DEPTH - 1; i++) exp_tail[i] = 8'(8'h21 + i);
      exp_tail[DEPTH-1] = 8'hEE;
      m_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("t3_drain%0d", i), 32'(m_data), 32'(exp_tail[i]));
         cycle();
      end
      m_ready = 1'b0;

      // Framing errors: a held level counts once
      rx_err = 1'b1; repeat (5) cycle();
      rx_err = 1'b0; cycle(); rx_err = 1'b1; cycle();
      rx_err = 1'b0; cycle(); rx_err = 1'b1; cycle();
      rx_err = 1'b0; cycle();
      chk("t4_err_cnt", 32'(err_cnt), 32'd3);
      chk("t4_frame_err", 32'(frame_err), 32'h1);
      chk("t4_level", 32'(level), 32'h0);
      clr_status = 1'b1; cycle(); clr_status = 1'b0;
      chk("t4_clr_cnt", 32'(err_cnt), 32'h0);
      chk("t4_clr_fe", 32'(frame_err), 32'h0);
      rx_err = 1'b1; clr_status = 1'b1; cycle();
      rx_err = 1'b0; clr_status = 1'b0;
      chk("t4_evt_wins", 32'(err_cnt), 32'h1);
      cycle();

      // Flush coinciding with a push
      for (int i = 0; i < 4; i++) push_byte(8'(8'h40 + i));
      flush = 1'b1; rx_data = 8'h77; rx_done = 1'b1; cycle();
      flush = 1'b0; rx_done = 1'b0;
      chk("t5_level", 32'(level), 32'h0);
      chk("t5_valid", 32'(m_valid), 32'h0);
      chk("t5_drop", 32'(drop_cnt), 32'h0);
      cycle();

      // Idle timeout: one byte, then silence
      idle_pulses = 0;
      push_byte(8'h99);
      repeat (IDLE_CLKS + 40) cycle();
`ifdef UART_RX_FIFO_IDLE_TIMEOUT_EN
      chk("t6_idle_pulses", 32'(idle_pulses), 32'd1);
`else
      chk("t6_idle_pulses", 32'(idle_pulses), 32'd0);
`endif
      flush = 1'b1; cycle(); flush = 1'b0;

      // Reset mid-stream
      push_byte(8'hC1); push_byte(8'hC2);
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      chk("t7_valid", 32'(m_valid), 32'h0);
      chk("t7_m_data", 32'(m_data), 32'h0);
      cycle();

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 2) == 0) rx_done = ~rx_done;
         rx_data    = 8'($urandom);
         if ($urandom_range(0, 7) == 0) rx_err = ~rx_err;
         m_ready    = ($urandom_range(0, 3) == 0) || (c >= 1000 && $urandom_range(0, 1) == 0);
         flush      = ($urandom_range(0, 59) == 0);
         clr_status = ($urandom_range(0, 49) == 0);
         rst_n      = ($urandom_range(0, 299) != 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
